// File: rtl/sram_req_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sram_req_ctrl_pkg
// Shared definitions for the SRAM request front-end.
//   PKG_ADDR_W / PKG_RAM_W : default macro geometry (256 x 34 fake SRAM)
//   PKG_DW                 : user data width (one bit narrower with parity)
//   DEPTH                  : macro word count
//   rsp_entry_t            : one response FIFO entry {data, perr}
//   parity_f               : even parity of a macro-width word
// Optional feature macro: SRAM_REQ_CTRL_PARITY_EN
// -----------------------------------------------------------------------------
package sram_req_ctrl_pkg;

    localparam int PKG_ADDR_W = 8;
    localparam int PKG_RAM_W  = 34;

`ifdef SRAM_REQ_CTRL_PARITY_EN
    // The macro MSB carries the parity bit, so users see one bit less.
    localparam int PKG_DW = PKG_RAM_W - 1;
`else
    localparam int PKG_DW = PKG_RAM_W;
`endif

    localparam int DEPTH = 2 ** PKG_ADDR_W;

    typedef struct packed {
        logic [PKG_DW-1:0] data;
        logic              perr;
    } rsp_entry_t;

    // Even parity: XOR of every bit, so a stored word with its parity bit
    // included reduces to 0 when intact.
    function automatic logic parity_f(input logic [PKG_RAM_W-1:0] i_word);
        return ^i_word;
    endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// -----------------------------------------------------------------------------
// sram_rsp_fifo
// Small synchronous FIFO holding read responses until the consumer takes them.
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_push        : write i_push_data at the tail
//   i_pop         : drop the head entry (ignored when empty)
//   o_head        : current head entry (all zeros after reset)
//   o_full/o_empty: occupancy flags
//   o_count       : number of stored entries
// ENTRIES must be a power of two so the pointers wrap by simple overflow.
// -----------------------------------------------------------------------------
module sram_rsp_fifo #(
    parameter  int WIDTH   = 35,
    parameter  int ENTRIES = 2,
    localparam int PW      = $clog2(ENTRIES),
    localparam int CW      = $clog2(ENTRIES) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [ENTRIES];
    logic [PW-1:0]    r_wrPtr;
    logic [PW-1:0]    r_rdPtr;
    logic [CW-1:0]    r_count;
    logic             w_doPop;

    assign w_doPop = i_pop && !o_empty;

    // Storage and pointers. Storage is cleared on reset so the head reads
    // as zero before anything has been pushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_mem[i] <= '0;
            end
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wrPtr] <= i_push_data;
                r_wrPtr        <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({i_push, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rdPtr];
    assign o_full  = (r_count == CW'(ENTRIES));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/sram_req_ctrl.sv
// -----------------------------------------------------------------------------
// sram_req_ctrl
// Valid/ready request front-end for a single-port fake SRAM macro
// (e.g. fakeram7_256x34). Reads return through a response FIFO so the
// consumer can stall without losing the macro's one-cycle read data.
//   clk, rst_n                     : clock, asynchronous active-low reset
//   req_valid/req_ready            : request handshake (fire = both high)
//   req_we, req_addr, req_wdata    : write flag, word address, write data
//   rsp_valid/rsp_ready            : response handshake
//   rsp_rdata, rsp_perr            : read data and parity error flag
//   sram_ce/we/addr/wd, sram_rd    : macro pins
// Optional feature macro: SRAM_REQ_CTRL_PARITY_EN (even parity in macro MSB).
// Parity is meaningless once OR-merging writes hit a nonzero word; that is
// left as-is. RAM_W overrides must be mirrored in the package, because the
// response entry type is sized there.
// -----------------------------------------------------------------------------
module sram_req_ctrl
    import sram_req_ctrl_pkg::*;
#(
    parameter  int ADDR_W    = PKG_ADDR_W,
    parameter  int RAM_W     = PKG_RAM_W,
    parameter  int RSP_DEPTH = 2,
    localparam int DW        = PKG_DW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DW-1:0]     req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DW-1:0]     rsp_rdata,
    output logic              rsp_perr,
    output logic              sram_ce,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [RAM_W-1:0]  sram_wd,
    input  logic [RAM_W-1:0]  sram_rd
);

    localparam int CW = $clog2(RSP_DEPTH) + 1;
    localparam int SW = CW + 1;

    logic          r_inflight;
    logic          w_fire;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [SW-1:0] w_pending;
    logic          w_creditOk;
    rsp_entry_t    w_pushEntry;
    rsp_entry_t    w_head;

    // Credit rule: a read may only fire if its response is guaranteed a
    // FIFO slot, counting what is stored, what is still in the macro, and
    // the slot freed by a pop this cycle.
    assign w_pending  = SW'(w_count) + SW'(r_inflight) - SW'(w_pop);
    assign w_creditOk = (w_pending < SW'(RSP_DEPTH));
    assign req_ready  = rst_n && (req_we || w_creditOk);
    assign w_fire     = req_valid && req_ready;

    // Idle cycles drive zeros so the macro never sees X or a stray access.
    assign sram_ce   = w_fire;
    assign sram_we   = w_fire && req_we;
    assign sram_addr = w_fire ? req_addr : '0;
`ifdef SRAM_REQ_CTRL_PARITY_EN
    assign sram_wd   = w_fire ? {parity_f(RAM_W'(req_wdata)), req_wdata} : '0;
`else
    assign sram_wd   = w_fire ? req_wdata : '0;
`endif

    // A read fired this cycle has its data on sram_rd next cycle; that is
    // the only cycle the macro output is sampled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_fire && !req_we;
        end
    end

    assign w_push = r_inflight;

`ifdef SRAM_REQ_CTRL_PARITY_EN
    assign w_pushEntry.data = sram_rd[RAM_W-2:0];
    assign w_pushEntry.perr = parity_f(sram_rd);
`else
    assign w_pushEntry.data = sram_rd;
    assign w_pushEntry.perr = 1'b0;
`endif

    sram_rsp_fifo #(
        .WIDTH   ($bits(rsp_entry_t)),
        .ENTRIES (RSP_DEPTH)
    ) u_rspFifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_pushEntry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    assign rsp_valid = !w_empty;
    assign w_pop     = rsp_valid && rsp_ready;
    assign rsp_rdata = w_head.data;
    // Without parity every stored perr bit is zero, so this stays low.
    assign rsp_perr  = w_head.perr;

    // The credit rule should make an overflowing push unreachable.
    assert property (@(posedge clk) disable iff (!rst_n)
                     !(w_push && w_full && !w_pop));

endmodule

// File: tb/tb_sram_req_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_req_ctrl
// Self-checking bench for sram_req_ctrl with a behavioural OR-merging macro
// model and a response scoreboard. Honours SRAM_REQ_CTRL_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_sram_req_ctrl;

    localparam int ADDR_W = 8;
    localparam int RAM_W  = 34;
`ifdef SRAM_REQ_CTRL_PARITY_EN
    localparam int DW  = RAM_W - 1;
    localparam bit PAR = 1'b1;
`else
    localparam int DW  = RAM_W;
    localparam bit PAR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DW-1:0]     req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_perr;
    logic              sram_ce;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [RAM_W-1:0]  sram_wd;
    logic [RAM_W-1:0]  sram_rd;

    logic [RAM_W-1:0]  sramMem  [256] = '{default: '0};
    logic [RAM_W-1:0]  modelMem [256] = '{default: '0};
    logic [RAM_W-1:0]  rdReg;
    logic [RAM_W-1:0]  flipMask = '0;
    logic [RAM_W-1:0]  monRaw;
    logic [DW:0]       monExp;
    logic [DW:0]       expQ [$];

    logic rspReadyCmd = 1'b1;
    logic randomReady = 1'b0;
    int   compared    = 0;
    int   mismatched  = 0;

    always #5 clk = ~clk;

    sram_req_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_perr  (rsp_perr),
        .sram_ce   (sram_ce),
        .sram_we   (sram_we),
        .sram_addr (sram_addr),
        .sram_wd   (sram_wd),
        .sram_rd   (sram_rd)
    );

    // Fake macro: writes OR into the stored word, read data appears one
    // cycle after ce and is undefined when not enabled.
    always @(posedge clk) begin
        if (sram_ce) begin
            rdReg <= sramMem[sram_addr];
            if (sram_we) begin
                sramMem[sram_addr] <= sramMem[sram_addr] | sram_wd;
            end
        end else begin
            rdReg <= 'x;
        end
    end

    assign sram_rd = rdReg ^ flipMask;

    function automatic logic [RAM_W-1:0] encode(input logic [DW-1:0] d);
`ifdef SRAM_REQ_CTRL_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Consumer ready: either a commanded level or a random stall pattern.
    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = randomReady ? 1'($urandom_range(0, 1)) : rspReadyCmd;
        end
    end

    // Scoreboard: model updated and expectations queued on fire, responses
    // compared on handshake; reset drops everything outstanding.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                expQ.delete();
            end else begin
                if (req_valid && req_ready) begin
                    if (req_we) begin
                        modelMem[req_addr] = modelMem[req_addr] | encode(req_wdata);
                    end else begin
                        monRaw = modelMem[req_addr] ^ flipMask;
                        monExp = {(PAR ? ^monRaw : 1'b0), monRaw[DW-1:0]};
                        expQ.push_back(monExp);
                    end
                end
                if (rsp_valid && rsp_ready) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpectedRsp", 64'd1, 64'd0);
                    end else begin
                        monExp = expQ.pop_front();
                        checkOutput("rspData", 64'(rsp_rdata), 64'(monExp[DW-1:0]));
                        checkOutput("rspPerr", 64'(rsp_perr), 64'(monExp[DW]));
                    end
                end
            end
        end
    end

    // Issue one request starting at posedge+1; returns at posedge+1 after it fires.
    task automatic applyStimulus(input logic we, input logic [ADDR_W-1:0] a,
                                 input logic [DW-1:0] d);
        int waitCycles = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        while (!req_ready && waitCycles < 100) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!req_ready) begin
            checkOutput("reqTimeout", 64'd0, 64'd1);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic waitDrain(input string tag);
        int guard = 0;
        @(negedge clk);
        while ((expQ.size() != 0 || rsp_valid) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checkOutput(tag, 64'(expQ.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstRspValid", 64'(rsp_valid), 64'd0);
        checkOutput("rstRspData",  64'(rsp_rdata), 64'd0);
        checkOutput("rstRspPerr",  64'(rsp_perr),  64'd0);
        checkOutput("rstCe",       64'(sram_ce),   64'd0);
        checkOutput("rstWe",       64'(sram_we),   64'd0);
        checkOutput("rstAddr",     64'(sram_addr), 64'd0);
        checkOutput("rstWd",       64'(sram_wd),   64'd0);
        checkOutput("rstReqReady", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Idle: no macro access and no responses.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("idleCe",       64'(sram_ce),   64'd0);
            checkOutput("idleAddr",     64'(sram_addr), 64'd0);
            checkOutput("idleRspValid", 64'(rsp_valid), 64'd0);
        end
        @(posedge clk);
        #1;

        // Write then read-after-write with exact response latency.
        applyStimulus(1'b1, 8'h10, DW'(34'h0_0000_00F0));
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 8'h10;
        @(negedge clk);
        checkOutput("rawReadReady", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = '0;
        @(negedge clk);
        checkOutput("latencyN1", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        checkOutput("latencyN2", 64'(rsp_valid), 64'd1);
        checkOutput("rawData",   64'(rsp_rdata), 64'hF0);
        waitDrain("drainRaw");

        // OR-merge of two writes to one word.
        applyStimulus(1'b1, 8'h22, DW'(8'h0F));
        applyStimulus(1'b1, 8'h22, DW'(8'hF0));
        applyStimulus(1'b0, 8'h22, '0);
        waitDrain("drainMerge");

        // Credit limit with a stalled consumer: third read must wait.
        rspReadyCmd = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        applyStimulus(1'b0, 8'h10, '0);
        applyStimulus(1'b0, 8'h22, '0);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 8'h05;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("creditBlock", 64'(req_ready), 64'd0);
        end
        checkOutput("creditRspPending", 64'(rsp_valid), 64'd1);
        rspReadyCmd = 1'b1;
        begin
            int guard = 0;
            @(negedge clk);
            while (!req_ready && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            checkOutput("creditRelease", 64'(req_ready), 64'd1);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = '0;
        waitDrain("drainCredit");

        // Reset while a read is in flight.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 8'h22;
        @(negedge clk);
        checkOutput("rstFlightReady", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = '0;
        rst_n     = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checkOutput("midRstRspValid", 64'(rsp_valid), 64'd0);
            checkOutput("midRstCe",       64'(sram_ce),   64'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("postRstRspValid", 64'(rsp_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 8'h10, '0);
        waitDrain("drainPostRst");

        // Bit flip on the macro output during a read, then a clean read.
        applyStimulus(1'b1, 8'h05, DW'(1));
        flipMask = RAM_W'(1);
        applyStimulus(1'b0, 8'h05, '0);
        waitDrain("drainFlip");
        flipMask = '0;
        applyStimulus(1'b0, 8'h05, '0);
        waitDrain("drainNoFlip");

        // Random mix with a randomly stalling consumer.
        randomReady = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [63:0] rnd;
            rnd = {$urandom, $urandom};
            applyStimulus(1'($urandom_range(0, 1)), ADDR_W'(8'h40 + $urandom_range(0, 7)),
                          rnd[DW-1:0]);
        end
        randomReady = 1'b0;
        waitDrain("drainRandom");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
